msrv32_mem_arbiter: RTL and testbench

- Shares one external single-port memory between the core's instruction-fetch path and its load/store path.
- Sequences one memory transaction at a time over a request/ready handshake with variable wait states.
- Returns registered read data and a one-cycle acknowledge to the winning requester, and stalls the core while any request is pending.
- Sits between the core top (PC/imm-adder address, store unit, load unit) and the memory or bus interface.

---
 rtl/msrv32_arb_pkg.sv | 22 ++
 rtl/msrv32_arb_priority.sv | 26 ++
 rtl/msrv32_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_msrv32_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_arb_pkg.sv
// Shared definitions for the msrv32 memory arbiter: FSM encoding,
// grant encoding, default parameters and the fetch byte mask.
package msrv32_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } arb_grant_e;

    localparam int unsigned ARB_STARVE_LIMIT_DEF   = 4;
    localparam int unsigned ARB_TIMEOUT_CYCLES_DEF = 255;
    localparam logic [3:0]  ARB_FETCH_MASK         = 4'hF;

endpackage

// File: rtl/msrv32_arb_priority.sv
// Combinational grant decision: data wins by default, fetch wins when
// it is alone or once it has lost STARVE_LIMIT arbitrations in a row.
module msrv32_arb_priority
    import msrv32_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
    input  logic       i_req_in,
    input  logic       d_req_in,
    input  logic [3:0] starve_cnt_in,
    output arb_grant_e grant_out
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    // Pick the winner from the live requests and the starvation count.
    always_comb begin
        grant_out = GNT_NONE;
        if (d_req_in && !(i_req_in && (starve_cnt_in == STARVE_LIM))) begin
            grant_out = GNT_D;
        end else if (i_req_in) begin
            grant_out = GNT_I;
        end
    end

endmodule

// File: rtl/msrv32_mem_arbiter.sv
// Fetch / load-store arbiter for one single-port memory.
// Optional bus timeout enabled by defining MSRV32_ARB_TIMEOUT_EN.
module msrv32_mem_arbiter
    import msrv32_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = ARB_STARVE_LIMIT_DEF,
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEF
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic [31:0] i_rdata_out,
    output logic        i_ack_out,
    input  logic        d_req_in,
    input  logic        d_we_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [3:0]  d_mask_in,
    output logic [31:0] d_rdata_out,
    output logic        d_ack_out,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [3:0]  mem_mask_out,
    input  logic [31:0] mem_rdata_in,
    input  logic        mem_ready_in,
    output logic        stall_out,
    output logic        err_out
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("msrv32_mem_arbiter: STARVE_LIMIT must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("msrv32_mem_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    arb_state_e  state_q, state_d;
    arb_grant_e  grant;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
`ifdef MSRV32_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
`endif

    msrv32_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_priority (
        .i_req_in      (i_req_in),
        .d_req_in      (d_req_in),
        .starve_cnt_in (starve_cnt_q),
        .grant_out     (grant)
    );

    // Next-state, grant latching, completion capture and ack generation.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_mask_d   = mem_mask_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
`ifdef MSRV32_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant == GNT_I) begin
                    state_d      = BUSY_I;
                    starve_cnt_d = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr_in;
                    mem_wdata_d  = '0;
                    mem_mask_d   = ARB_FETCH_MASK;
`ifdef MSRV32_ARB_TIMEOUT_EN
                    tmo_cnt_d    = '0;
`endif
                end else if (grant == GNT_D) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_in;
                    mem_addr_d  = d_addr_in;
                    mem_wdata_d = d_wdata_in;
                    mem_mask_d  = d_mask_in;
                    if (i_req_in && (starve_cnt_q != STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
`ifdef MSRV32_ARB_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready_in) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = mem_rdata_in;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_we_q ? '0 : mem_rdata_in;
                    end
`ifdef MSRV32_ARB_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_mask_q   <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
`ifdef MSRV32_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_mask_q   <= mem_mask_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
`ifdef MSRV32_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign mem_req_out   = mem_req_q;
    assign mem_we_out    = mem_we_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_wdata_out = mem_wdata_q;
    assign mem_mask_out  = mem_mask_q;
    assign i_ack_out     = i_ack_q;
    assign d_ack_out     = d_ack_q;
    assign i_rdata_out   = i_rdata_q;
    assign d_rdata_out   = d_rdata_q;
    assign stall_out     = (i_req_in & ~i_ack_q) | (d_req_in & ~d_ack_q);
`ifdef MSRV32_ARB_TIMEOUT_EN
    assign err_out       = err_q;
`else
    assign err_out       = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_mem_arbiter.sv
// Directed bench for msrv32_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_msrv32_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic        err;

    int checks   = 0;
    int failures = 0;

    msrv32_mem_arbiter #(
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .i_req_in             (i_req),
        .i_addr_in            (i_addr),
        .i_rdata_out          (i_rdata),
        .i_ack_out            (i_ack),
        .d_req_in             (d_req),
        .d_we_in              (d_we),
        .d_addr_in            (d_addr),
        .d_wdata_in           (d_wdata),
        .d_mask_in            (d_mask),
        .d_rdata_out          (d_rdata),
        .d_ack_out            (d_ack),
        .mem_req_out          (mem_req),
        .mem_we_out           (mem_we),
        .mem_addr_out         (mem_addr),
        .mem_wdata_out        (mem_wdata),
        .mem_mask_out         (mem_mask),
        .mem_rdata_in         (mem_rdata),
        .mem_ready_in         (mem_ready),
        .stall_out            (stall),
        .err_out              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step until an ack appears; returns which one. Expiry counts as a failure.
    task automatic wait_ack(input string tag, output logic gi, output logic gd);
        bit seen;
        seen = 1'b0;
        gi   = 1'b0;
        gd   = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (i_ack || d_ack) begin
                seen = 1'b1;
                gi   = i_ack;
                gd   = d_ack;
            end
        end
        chk({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
    endtask

    logic gi, gd;
    logic exp_i;

    initial begin
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_mask    = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        step();

        // Fetch, ready two cycles after mem_req rises
        i_req  = 1'b1;
        i_addr = 32'h0000_0100;
        #1;
        chk("f_stall_req", {31'd0, stall}, 32'd1);
        step();
        chk("f_c1_req", {31'd0, mem_req}, 32'd1);
        chk("f_c1_addr", mem_addr, 32'h0000_0100);
        chk("f_c1_we_mask", {27'd0, mem_we, mem_mask}, {27'd0, 1'b0, 4'hF});
        step();
        chk("f_c2_req", {31'd0, mem_req}, 32'd1);
        step();
        chk("f_c3_req", {31'd0, mem_req}, 32'd1);
        chk("f_c3_ack", {31'd0, i_ack}, 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0013;
        step();
        chk("f_ack", {30'd0, i_ack, d_ack}, 32'd2);
        chk("f_rdata", i_rdata, 32'h0000_0013);
        chk("f_resp_req", {31'd0, mem_req}, 32'd0);
        chk("f_stall_ack", {31'd0, stall}, 32'd0);
        mem_ready = 1'b0;
        i_req     = 1'b0;
        step();
        chk("f_ack_pulse", {31'd0, i_ack}, 32'd0);

        // Load to put a known value in d_rdata
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h0000_3000;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        chk("ld_we", {31'd0, mem_we}, 32'd0);
        step();
        chk("ld_ack", {30'd0, i_ack, d_ack}, 32'd1);
        chk("ld_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        step();

        // Store, ready immediate
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h0000_2004;
        d_wdata   = 32'hDEAD_BEEF;
        d_mask    = 4'b0011;
        mem_rdata = 32'h5555_AAAA;
        step();
        chk("st_req_we", {30'd0, mem_req, mem_we}, 32'd3);
        chk("st_addr", mem_addr, 32'h0000_2004);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mask", {28'd0, mem_mask}, 32'h3);
        chk("st_no_ack_yet", {30'd0, i_ack, d_ack}, 32'd0);
        step();
        chk("st_ack", {30'd0, i_ack, d_ack}, 32'd1);
        chk("st_rdata_zero", d_rdata, 32'd0);
        chk("st_i_rdata_hold", i_rdata, 32'h0000_0013);
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("st_ack_pulse", {31'd0, d_ack}, 32'd0);

        // Both requests held: D D D D I D D D D I
        i_req     = 1'b1;
        i_addr    = 32'h0000_0200;
        d_req     = 1'b1;
        d_addr    = 32'h0000_4000;
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mem_rdata = 32'h1000_0000 + k;
            wait_ack("arb", gi, gd);
            exp_i = (k == 4) || (k == 9);
            chk($sformatf("arb_grant_%0d", k), {30'd0, gi, gd}, {30'd0, exp_i, ~exp_i});
            if (exp_i) chk($sformatf("arb_irdata_%0d", k), i_rdata, 32'h1000_0000 + k);
            else       chk($sformatf("arb_drdata_%0d", k), d_rdata, 32'h1000_0000 + k);
        end
        i_req     = 1'b0;
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();
        step();

        // Reset in BUSY_D abandons the load
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_5000;
        step();
        chk("rb_busy", {31'd0, mem_req}, 32'd1);
        step();
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("rb_req_cleared", {31'd0, mem_req}, 32'd0);
        chk("rb_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
        chk("rb_d_rdata", d_rdata, 32'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        step();
        chk("rb_regrant", {31'd0, mem_req}, 32'd1);
        chk("rb_regrant_addr", mem_addr, 32'h0000_5000);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        chk("rb_ack", {30'd0, i_ack, d_ack}, 32'd1);
        chk("rb_rdata", d_rdata, 32'h1234_5678);
        d_req     = 1'b0;
        mem_ready = 1'b0;
        step();

        // Store whose request drops mid-access still completes
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_6000;
        d_wdata = 32'h0BAD_F00D;
        d_mask  = 4'b1100;
        step();
        chk("drop_c1", {30'd0, mem_req, mem_we}, 32'd3);
        step();
        d_req = 1'b0;
        d_we  = 1'b0;
        #1;
        chk("drop_stall", {31'd0, stall}, 32'd0);
        chk("drop_c2_req", {31'd0, mem_req}, 32'd1);
        step();
        chk("drop_c3_hold", mem_wdata, 32'h0BAD_F00D);
        chk("drop_c3_we_mask", {27'd0, mem_we, mem_mask}, {27'd0, 1'b1, 4'b1100});
        mem_ready = 1'b1;
        step();
        chk("drop_ack", {30'd0, i_ack, d_ack}, 32'd1);
        mem_ready = 1'b0;
        step();
        chk("drop_ack_once", {30'd0, i_ack, d_ack}, 32'd0);
        chk("drop_idle_req", {31'd0, mem_req}, 32'd0);

`ifdef MSRV32_ARB_TIMEOUT_EN
        // Fetch with no ready times out after 8 BUSY cycles
        i_req  = 1'b1;
        i_addr = 32'h0000_0300;
        step();
        for (int c = 2; c <= 8; c++) step();
        chk("to_c8_busy", {31'd0, mem_req}, 32'd1);
        chk("to_c8_no_ack", {31'd0, i_ack}, 32'd0);
        step();
        chk("to_ack_err", {29'd0, i_ack, d_ack, err}, 32'b101);
        chk("to_rdata", i_rdata, 32'd0);
        i_req = 1'b0;
        step();
        chk("to_err_pulse", {31'd0, err}, 32'd0);

        // Ready exactly at the timeout cycle wins
        i_req = 1'b1;
        step();
        for (int c = 2; c <= 8; c++) step();
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0077;
        step();
        chk("to_race_ack_err", {29'd0, i_ack, d_ack, err}, 32'b100);
        chk("to_race_rdata", i_rdata, 32'h0000_0077);
        i_req     = 1'b0;
        mem_ready = 1'b0;
        step();
`else
        chk("err_tied", {31'd0, err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
